// File: rtl/entropy_pkg.sv
// Shared types and default sizing for the entropy collector.
package entropy_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_SAMPLE_DIV = 4;
  localparam int DEF_RCT_CUTOFF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAIL    = 2'd3
  } ec_state_e;

  // Counter width helper that never returns 0 bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous bit.
module bit_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// Samples a raw oscillator bit, Von Neumann debiases it and packs words for a
// valid/ready consumer. Define ENTROPY_HEALTH_EN to add the repetition-count test.
module entropy_collector
  import entropy_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  raw_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  health_fail,
  input  logic                  health_clr
);

  localparam int DIV_W = clog2_min1(SAMPLE_DIV);
  localparam int CNT_W = clog2_min1(WORD_WIDTH);

  ec_state_e             state;
  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WORD_WIDTH-1:0] acc;
  logic [WORD_WIDTH-1:0] acc_next;
  logic                  pair_phase;
  logic                  first_bit;
  logic                  raw_s;
  logic                  strobe;
  logic                  emit;
  logic                  word_done;
  logic                  rct_trip;

  bit_synchronizer u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_bit),
    .q     (raw_s)
  );

  // Sampling only happens in COLLECT with en still high; a drop of en wins.
  assign strobe    = (state == ST_COLLECT) && en && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign emit      = strobe && pair_phase && (first_bit != raw_s);
  assign acc_next  = {acc[WORD_WIDTH-2:0], first_bit};
  assign word_done = emit && (bit_cnt == CNT_W'(WORD_WIDTH - 1));

`ifdef ENTROPY_HEALTH_EN
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_next;
  logic             last_sample;

  assign run_next = ((run_cnt != '0) && (raw_s == last_sample)) ? run_cnt + 1'b1 : RUN_W'(1);
  assign rct_trip = strobe && (run_next == RUN_W'(RCT_CUTOFF));

  // The run counter spans IDLE/FULL gaps; only a clear or reset restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_fail <= 1'b0;
      run_cnt     <= '0;
      last_sample <= 1'b0;
    end else if ((state == ST_FAIL) && health_clr) begin
      health_fail <= 1'b0;
      run_cnt     <= '0;
    end else begin
      if (rct_trip) health_fail <= 1'b1;
      if (strobe) begin
        run_cnt     <= run_next;
        last_sample <= raw_s;
      end
    end
  end
`else
  logic unused_health_clr;

  assign unused_health_clr = health_clr;
  assign rct_trip          = 1'b0;
  assign health_fail       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      pair_phase <= 1'b0;
      first_bit  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state   <= ST_COLLECT;
            div_cnt <= '0;
          end
        end

        ST_COLLECT: begin
          if (!en || rct_trip) begin
            state      <= en ? ST_FAIL : ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            pair_phase <= 1'b0;
            out_valid  <= 1'b0;
          end else begin
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;
            if (strobe && !pair_phase) begin
              pair_phase <= 1'b1;
              first_bit  <= raw_s;
            end else if (strobe) begin
              pair_phase <= 1'b0;
              if (emit) begin
                acc <= acc_next;
                if (word_done) begin
                  out_data  <= acc_next;
                  out_valid <= 1'b1;
                  bit_cnt   <= '0;
                  state     <= ST_FULL;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            end
          end
        end

        ST_FULL: begin
          if (!en || (out_valid && out_ready)) begin
            state      <= en ? ST_COLLECT : ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            pair_phase <= 1'b0;
            out_valid  <= 1'b0;
          end
        end

`ifdef ENTROPY_HEALTH_EN
        ST_FAIL: begin
          if (health_clr) state <= ST_IDLE;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Randomized bench for entropy_collector with a sample-level reference model.
module tb_entropy_collector;

  localparam int W    = 32;
  localparam int SDIV = 4;
  localparam int CUT  = 16;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         en         = 1'b0;
  logic         raw_bit    = 1'b0;
  logic         out_ready  = 1'b0;
  logic         health_clr = 1'b0;
  logic         out_valid;
  logic         health_fail;
  logic [W-1:0] out_data;

  int vecs = 0;
  int errs = 0;

  // Reference model state: pair phase, packed bits, run of identical samples.
  bit           m_have;
  bit           m_first;
  int           m_nbits;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_word;
  bit           m_last;
  int           m_run;
  bit           done_f;
  bit           fail_f;
  bit           pat2 [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  entropy_collector #(
    .WORD_WIDTH (W),
    .SAMPLE_DIV (SDIV),
    .RCT_CUTOFF (CUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .raw_bit     (raw_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .health_fail (health_fail),
    .health_clr  (health_clr)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_word();
    m_have  = 1'b0;
    m_nbits = 0;
    m_acc   = '0;
  endtask

  function automatic bit gen_rand();
    bit b;
    b = 1'($urandom_range(0, 1));
    if (m_run >= 8 && b == m_last) b = ~m_last;
    return b;
  endfunction

  // One strobed sample: predict, drive for a full divider period, then check.
  task automatic feed(input bit b);
    done_f = 1'b0;
    fail_f = 1'b0;
    m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
    m_last = b;
`ifdef ENTROPY_HEALTH_EN
    if (m_run == CUT) fail_f = 1'b1;
`endif
    if (fail_f) begin
      clear_word();
    end else if (!m_have) begin
      m_have  = 1'b1;
      m_first = b;
    end else begin
      m_have = 1'b0;
      if (m_first != b) begin
        m_acc = {m_acc[W-2:0], m_first};
        m_nbits++;
        if (m_nbits == W) begin
          done_f  = 1'b1;
          m_word  = m_acc;
          m_nbits = 0;
          m_acc   = '0;
        end
      end
    end
    raw_bit   = b;
    out_ready = (done_f || fail_f) ? 1'b0 : 1'($urandom_range(0, 1));
    repeat (SDIV) @(negedge clk);
    if (fail_f) begin
      chk("rct_trip", health_fail, 1);
      chk("fail_valid", out_valid, 0);
    end else begin
      chk("hf_quiet", health_fail, 0);
      if (done_f) begin
        chk("word_valid", out_valid, 1);
        chk("word_data", out_data, m_word);
      end else begin
        chk("valid_low", out_valid, 0);
      end
    end
  endtask

  task automatic collect_word(input int mode);
    int k;
    bit b;
    k      = 0;
    done_f = 1'b0;
    while (!done_f && k < 4000) begin
      case (mode)
        1:       b = (k % 2 == 0);
        2:       b = pat2[k % 8];
        default: b = gen_rand();
      endcase
      feed(b);
      k++;
    end
    if (!done_f) chk("word_timeout", 0, 1);
  endtask

  task automatic accept(input int stall);
    for (int i = 0; i < stall; i++) begin
      raw_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, m_word);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("xfer_valid", out_valid, 0);
    chk("xfer_data", out_data, m_word);
  endtask

  task automatic start();
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop();
    en = 1'b0;
    @(negedge clk);
    clear_word();
    chk("stop_valid", out_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_hf", health_fail, 0);
    en         = 1'b0;
    out_ready  = 1'b0;
    health_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_word();
    m_run  = 0;
    m_last = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int k;
    clear_word();
    m_run  = 0;
    m_last = 1'b0;
    m_word = '0;
    repeat (2) @(negedge clk);
    chk("init_valid", out_valid, 0);
    chk("init_data", out_data, 0);
    chk("init_hf", health_fail, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1,0 samples pack all ones; 0,1 with 11/00 pairs mixed in pack all zeros
    start();
    collect_word(1);
    chk("all_ones", out_data, 32'hFFFF_FFFF);
    accept(0);
    collect_word(2);
    chk("all_zero", out_data, 32'h0);
    accept(100);

    repeat (4) begin
      collect_word(0);
      accept($urandom_range(0, 6));
    end

    // Reset after 20 bits discards the partial word
    k = 0;
    while (m_nbits < 20 && k < 2000) begin
      feed(gen_rand());
      k++;
    end
    do_reset();
    start();
    collect_word(0);
    accept(2);

    // en dropped while a word is waiting
    collect_word(0);
    en = 1'b0;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, m_word);
    clear_word();
    start();
    collect_word(0);
    accept(1);

    // en dropped mid-word
    repeat (30) feed(gen_rand());
    stop();
    start();
    collect_word(0);
    accept(0);

    // Constant raw bit exercises the repetition-count test
    do_reset();
    start();
    repeat (CUT) feed(1'b1);
`ifdef ENTROPY_HEALTH_EN
    repeat (6) begin
      en      = ~en;
      raw_bit = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      chk("fail_hold_hf", health_fail, 1);
      chk("fail_hold_valid", out_valid, 0);
    end
    en         = 1'b0;
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    chk("clr_hf", health_fail, 0);
    m_run = 0;
    clear_word();
    start();
    collect_word(0);
    accept(0);
`else
    health_clr = 1'b1;
    @(negedge clk);
    health_clr = 1'b0;
    chk("clr_ignored", health_fail, 0);
    collect_word(0);
    accept(0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/entropy_collector.md
ENTROPY_COLLECTOR -- requirements
Module: entropy_collector

Interface
REQ-001 Parameter WORD_WIDTH, default 32, is the width of each delivered entropy word.
REQ-002 Parameter SAMPLE_DIV, default 4, is the number of clk cycles between raw-bit samples (minimum 1).
REQ-003 Parameter RCT_CUTOFF, default 16, is the repetition-count limit for consecutive identical raw samples (minimum 2).
REQ-004 Port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port en, input, 1 bit: collection enable.
REQ-007 Port raw_bit, input, 1 bit: free-running oscillator-sampled random bit, asynchronous to clk.
REQ-008 Port out_valid, output, 1 bit: out_data holds a complete word.
REQ-009 Port out_ready, input, 1 bit: consumer accepts out_data this cycle.
REQ-010 Port out_data, output, WORD_WIDTH bits: delivered entropy word.
REQ-011 Port health_fail, output, 1 bit: sticky health-test failure flag.
REQ-012 Port health_clr, input, 1 bit: clears health_fail.

Function
REQ-013 raw_bit SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-014 A divider counter 0..SAMPLE_DIV-1 SHALL run while in COLLECT and produce a sample strobe in the cycle it equals SAMPLE_DIV-1, then wrap to 0.
REQ-015 States SHALL be IDLE, COLLECT, FULL, plus FAIL when health is compiled in.
REQ-016 IDLE->COLLECT when en=1; any state except FAIL -> IDLE when en=0, clearing accumulator, bit count, pair phase, divider and out_valid; out_data retains its value.
REQ-017 Von Neumann debiasing: first strobed sample of a pair is held; on the second, pair 01 emits 0, pair 10 emits 1, pairs 00/11 emit nothing; pair phase then resets.
REQ-018 Each emitted bit SHALL shift into the accumulator LSB: acc <= {acc[WORD_WIDTH-2:0], bit}.
REQ-019 On the WORD_WIDTH-th emitted bit, out_data SHALL load the completed word, out_valid SHALL rise the next cycle, and the state SHALL become FULL.
REQ-020 In FULL, divider and sampling SHALL pause; out_data and out_valid SHALL be held stable while out_ready=0.
REQ-021 A transfer occurs when out_valid=1 and out_ready=1; the next cycle out_valid=0, state COLLECT with bit count, pair phase and divider cleared (IDLE if en=0).
REQ-022 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-023 While rst_n=0: state IDLE, out_valid=0, out_data=0, health_fail=0, accumulator, counters, synchronizer flops and pair phase 0.
REQ-024 Reset mid-collection or mid-handshake SHALL discard all partial and held data with no transfer completed.

Configuration
REQ-025 Macro ENTROPY_HEALTH_EN compiles in the repetition-count test and FAIL state.
REQ-026 With it: a run counter SHALL count consecutive identical strobed samples (restart at 1 on change); reaching RCT_CUTOFF sets health_fail, clears accumulator, counters and out_valid, and enters FAIL.
REQ-027 In FAIL, no sampling occurs regardless of en; health_clr=1 clears health_fail and the run counter and moves to IDLE; a failure event and health_clr in the same cycle: failure wins.
REQ-028 Without it: health_fail SHALL be tied 0, health_clr ignored, FAIL state absent.

Structure
REQ-029 Shared package entropy_pkg SHALL hold the state enum and default constants for WORD_WIDTH, SAMPLE_DIV, RCT_CUTOFF.
REQ-030 The 2-flop synchronizer SHALL be a separate sub-module bit_synchronizer, async-reset active-low.

Verification
REQ-031 raw_bit toggled so strobed samples are 1,0 repeatedly, SAMPLE_DIV=4, out_ready=1 -> out_valid after 64 samples, out_data=32'hFFFFFFFF.
REQ-032 Strobed samples repeating 0,1 -> out_data=32'h00000000; interleaved 11/00 pairs -> no emitted bits, word count unchanged.
REQ-033 out_ready=0 for 100 cycles after out_valid -> out_data/out_valid stable, no sampling; single out_ready pulse -> out_valid=0 next cycle.
REQ-034 With ENTROPY_HEALTH_EN, raw_bit held 1 -> health_fail=1 on 16th identical sample, out_valid=0; en toggling ignored until health_clr pulse returns IDLE.
REQ-035 rst_n pulsed low after 20 emitted bits -> all outputs 0 immediately; next word needs full 32 fresh bits.
REQ-036 en dropped in FULL -> out_valid=0 next cycle, out_data unchanged, state IDLE.
